// File: rtl/calc_queue_pkg.sv
// Shared constants and types for the queue calculator operand queue.
// Opcodes, FSM state encoding and default geometry.
package calc_queue_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] Q_PUSH         = 2'b00;
  localparam logic [1:0] Q_SLEEP        = 2'b01;
  localparam logic [1:0] Q_POP          = 2'b11;
  localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/queue_regfile.sv
// DEPTH x WIDTH storage array for calc_queue: one write port, two async read ports.
// Contents are intentionally not reset; the parent masks reads by occupancy.
module queue_regfile #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/calc_queue.sv
// Operand queue for the queue calculator: circular FIFO with sticky error halt.
// Optional peak-occupancy register enabled by defining CALC_QUEUE_HWM_EN.
//
//   state | meaning
//   RUN   | ops accepted, op_ready=1
//   HALT  | error latched, everything frozen until err_clr
module calc_queue
  import calc_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         queue_op,
  input  logic [WIDTH-1:0]   push_val,
  input  logic               calc_err,
  input  logic               err_clr,
  output logic [2*WIDTH-1:0] operands,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full,
  output logic               err_under,
  output logic               err_over,
  output logic               err_calc,
  output logic [CW-1:0]      hwm
);

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic            accept;
  logic            do_push, do_pop1, do_pop2;
  logic            set_under, set_over, set_calc, any_err;
  logic [WIDTH-1:0] rd0, rd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (any_err) state_d = HALT;
      HALT:    if (err_clr) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    op_ready = (state_q == RUN);
  end

  assign accept = op_valid & op_ready;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));

  // A calc error squashes the op entirely, so it takes precedence over range checks.
  always_comb begin
    do_push   = 1'b0;
    do_pop1   = 1'b0;
    do_pop2   = 1'b0;
    set_under = 1'b0;
    set_over  = 1'b0;
    set_calc  = 1'b0;
    if (accept) begin
      if (calc_err) begin
        set_calc = 1'b1;
      end else begin
        case (queue_op)
          Q_PUSH: begin
            if (full) set_over = 1'b1;
            else      do_push  = 1'b1;
          end
          Q_POP: begin
            if (empty) set_under = 1'b1;
            else       do_pop1   = 1'b1;
          end
          Q_GET_AND_PUSH: begin
            if (count_q < CW'(2)) begin
              set_under = 1'b1;
            end else begin
              do_pop2 = 1'b1;
              do_push = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign any_err = set_under | set_over | set_calc;

  always_comb begin
    count_d = count_q;
    if (do_pop2)      count_d = count_q - CW'(1);
    else if (do_pop1) count_d = count_q - CW'(1);
    else if (do_push) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop2)      head_q <= head_q + AW'(2);
      else if (do_pop1) head_q <= head_q + AW'(1);
      if (do_push)      tail_q <= tail_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_under <= 1'b0;
      err_over  <= 1'b0;
      err_calc  <= 1'b0;
    end else if (state_q == HALT && err_clr) begin
      err_under <= 1'b0;
      err_over  <= 1'b0;
      err_calc  <= 1'b0;
    end else begin
      err_under <= err_under | set_under;
      err_over  <= err_over  | set_over;
      err_calc  <= err_calc  | set_calc;
    end
  end

  queue_regfile #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_regfile (
    .clk    (clk),
    .we     (do_push),
    .waddr  (tail_q),
    .wdata  (push_val),
    .raddr0 (head_q),
    .raddr1 (head_q + AW'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  // Storage is never reset, so slots beyond the occupancy must read as zero.
  assign operands = {(count_q >= CW'(2)) ? rd1 : '0,
                     (count_q != '0)     ? rd0 : '0};
  assign count    = count_q;

`ifdef CALC_QUEUE_HWM_EN
  logic [CW-1:0] hwm_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  hwm_q <= '0;
    else if (count_d > hwm_q)  hwm_q <= count_d;
  end
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_calc_queue.sv
// Scoreboard bench for calc_queue: a reference FIFO model predicts outputs per op.
// Define CALC_QUEUE_HWM_EN for both RTL and bench to check the peak register.
module tb_calc_queue;
  import calc_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  queue_op;
  logic [7:0]  push_val;
  logic        calc_err;
  logic        err_clr;
  logic [15:0] operands;
  logic [4:0]  count;
  logic        empty, full, err_under, err_over, err_calc;
  logic [4:0]  hwm;

  calc_queue dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .queue_op(queue_op), .push_val(push_val), .calc_err(calc_err), .err_clr(err_clr),
    .operands(operands), .count(count), .empty(empty), .full(full),
    .err_under(err_under), .err_over(err_over), .err_calc(err_calc), .hwm(hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] opnds;
    logic [4:0]  cnt;
    logic        rdy, emp, ful, eu, eo, ec;
    logic [4:0]  peak;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_halt, m_eu, m_eo, m_ec;
  int         m_hwm;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.opnds = {(mq.size() >= 2) ? mq[1] : 8'h00, (mq.size() >= 1) ? mq[0] : 8'h00};
    e.cnt   = 5'(mq.size());
    e.rdy   = !m_halt;
    e.emp   = (mq.size() == 0);
    e.ful   = (mq.size() == 16);
    e.eu    = m_eu;
    e.eo    = m_eo;
    e.ec    = m_ec;
`ifdef CALC_QUEUE_HWM_EN
    e.peak  = 5'(m_hwm);
`else
    e.peak  = 5'd0;
`endif
    return e;
  endfunction

  function automatic void model_step(input bit v, input logic [1:0] op, input logic [7:0] val,
                                     input bit ce, input bit clr);
    logic [7:0] tmp;
    if (m_halt) begin
      if (clr) begin
        m_halt = 0; m_eu = 0; m_eo = 0; m_ec = 0;
      end
    end else if (v) begin
      if (ce) begin
        m_ec = 1; m_halt = 1;
      end else if (op == Q_PUSH) begin
        if (mq.size() == 16) begin m_eo = 1; m_halt = 1; end
        else mq.push_back(val);
      end else if (op == Q_POP) begin
        if (mq.size() == 0) begin m_eu = 1; m_halt = 1; end
        else tmp = mq.pop_front();
      end else if (op == Q_GET_AND_PUSH) begin
        if (mq.size() < 2) begin m_eu = 1; m_halt = 1; end
        else begin
          tmp = mq.pop_front();
          tmp = mq.pop_front();
          mq.push_back(val);
        end
      end
    end
    if (mq.size() > m_hwm) m_hwm = mq.size();
  endfunction

  task automatic compare_head(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, ".operands"}, 32'(operands), 32'(e.opnds));
    check_val({tag, ".count"},    32'(count),    32'(e.cnt));
    check_val({tag, ".op_ready"}, 32'(op_ready), 32'(e.rdy));
    check_val({tag, ".empty"},    32'(empty),    32'(e.emp));
    check_val({tag, ".full"},     32'(full),     32'(e.ful));
    check_val({tag, ".err_under"},32'(err_under),32'(e.eu));
    check_val({tag, ".err_over"}, 32'(err_over), 32'(e.eo));
    check_val({tag, ".err_calc"}, 32'(err_calc), 32'(e.ec));
    check_val({tag, ".hwm"},      32'(hwm),      32'(e.peak));
  endtask

  task automatic drive(input string tag, input bit v, input logic [1:0] op, input logic [7:0] val,
                       input bit ce = 0, input bit clr = 0);
    op_valid = v; queue_op = op; push_val = val; calc_err = ce; err_clr = clr;
    model_step(v, op, val, ce, clr);
    exp_q.push_back(snapshot());
    @(posedge clk);
    #1;
    op_valid = 0; queue_op = Q_SLEEP; push_val = 8'h00; calc_err = 0; err_clr = 0;
    compare_head(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_halt = 0; m_eu = 0; m_eo = 0; m_ec = 0; m_hwm = 0;
  endtask

  initial begin
    rst = 0; op_valid = 0; queue_op = Q_SLEEP; push_val = 0; calc_err = 0; err_clr = 0;
    model_reset();
    #12;
    exp_q.push_back(snapshot());
    compare_head("reset");
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    drive("push5", 1, Q_PUSH, 8'h05);
    drive("push3", 1, Q_PUSH, 8'h03);
    check_val("first_pair", 32'(operands), 32'h0305);
    drive("gap02", 1, Q_GET_AND_PUSH, 8'h02);
    check_val("gap_result", 32'(operands), 32'h0002);

    drive("pop_last", 1, Q_POP, 8'h00);
    drive("pop_empty", 1, Q_POP, 8'h00);
    drive("halt_push_ignored", 1, Q_PUSH, 8'h44);
    drive("clr_under", 0, Q_SLEEP, 8'h00, 0, 1);
    drive("push9", 1, Q_PUSH, 8'h09);
    drive("gap_count1", 1, Q_GET_AND_PUSH, 8'h55);
    drive("clr_gap", 1, Q_PUSH, 8'h66, 0, 1);
    drive("pop_to_empty", 1, Q_POP, 8'h00);

    for (int i = 0; i < 16; i++) drive("fill", 1, Q_PUSH, 8'(8'h10 + i));
    drive("push_full", 1, Q_PUSH, 8'hEE);
    drive("clr_over", 0, Q_SLEEP, 8'h00, 0, 1);
    drive("sleep", 1, Q_SLEEP, 8'h77);

    for (int i = 0; i < 20; i++) begin
      drive("wrap_gap",  1, Q_GET_AND_PUSH, 8'($urandom_range(0, 255)));
      drive("wrap_push", 1, Q_PUSH,         8'($urandom_range(0, 255)));
    end
    while (mq.size() > 0) drive("drain", 1, Q_POP, 8'h00);

    drive("push7", 1, Q_PUSH, 8'h07);
    drive("push0", 1, Q_PUSH, 8'h00);
    drive("gap_calc_err", 1, Q_GET_AND_PUSH, 8'h99, 1, 0);
    drive("halt_gap_ignored", 1, Q_GET_AND_PUSH, 8'h12);
    drive("clr_calc", 0, Q_SLEEP, 8'h00, 0, 1);

    for (int i = 0; i < 7; i++) drive("to_nine", 1, Q_PUSH, 8'(8'hA0 + i));
    check_val("pre_reset_count", 32'(count), 32'd9);
    #2;
    rst = 0;
    model_reset();
    #1;
    exp_q.push_back(snapshot());
    compare_head("async_reset");
    @(negedge clk); #1;
    rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) drive("hwm_fill", 1, Q_PUSH, 8'(i));
    for (int i = 0; i < 12; i++) drive("hwm_drain", 1, Q_POP, 8'h00);
`ifdef CALC_QUEUE_HWM_EN
    check_val("hwm_peak", 32'(hwm), 32'd12);
`else
    check_val("hwm_tied", 32'(hwm), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
